// File: rtl/uart_rx_core_if.sv
// Receive-side signal bundle for uart_rx_core: serial line in, word and status out.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx_data;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_busy;

  // Receiver side: samples the line, drives the word and status.
  modport master (
    input  i_rx_data,
    output o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_break, o_busy
  );

  // Consumer side: drives the line, reads the word and status.
  modport slave (
    output i_rx_data,
    input  o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_break, o_busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: synchroniser, 3-sample majority vote,
// parity / framing / break detection and a one-cycle valid strobe.
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_core_if.master rx
);
  localparam int MID = OVERSAMPLE / 2;
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_ONE = PW'(1);
  localparam logic [PW-1:0] PH_LO  = PW'(MID - 1);
  localparam logic [PW-1:0] PH_MID = PW'(MID);
  localparam logic [PW-1:0] PH_DEC = PW'(MID + 1);
  localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PEN     = (PARITY_EN != 0);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rxs, rxs_prev;
  logic [PW-1:0]        phase, phase_n;
  logic [3:0]           bit_idx, idx_n;
  logic                 samp_lo, samp_mid, maj;
  logic                 at_dec, at_end, start_det, frame_done;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, ferr_acc, zero_acc;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, brk_q;

  assign at_dec = (phase == PH_DEC);
  assign at_end = (phase == PH_END);
  assign maj    = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);

  assign rx.o_rx_data    = data_q;
  assign rx.o_rx_valid   = valid_q;
  assign rx.o_parity_err = perr_q;
  assign rx.o_frame_err  = ferr_q;
  assign rx.o_break      = brk_q;
  assign rx.o_busy       = (state != IDLE);

  // Two-flop synchroniser plus the previous synchronised value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx.i_rx_data;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, bit phase and bit index; the detect cycle counts as phase 0 of the start bit.
  always_comb begin
    state_n    = state;
    phase_n    = at_end ? '0 : phase + PH_ONE;
    idx_n      = bit_idx;
    start_det  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        phase_n = '0;
        idx_n   = '0;
        if (rxs_prev && !rxs) begin
          state_n   = START;
          phase_n   = PH_ONE;
          start_det = 1'b1;
        end
      end
      START: begin
        if (at_dec && maj) begin
          state_n = IDLE;
          phase_n = '0;
        end else if (at_end) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (at_end) begin
          if (bit_idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = PEN ? PARITY : STOP;
          end else begin
            idx_n = bit_idx + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_end) begin
          state_n = STOP;
          idx_n   = '0;
        end
      end
      STOP: begin
        // Leave mid-bit after the last decision so the next start edge is never missed.
        if (at_dec && bit_idx == LAST_STOP) begin
          frame_done = 1'b1;
          state_n    = IDLE;
          phase_n    = '0;
          idx_n      = '0;
        end else if (at_end) begin
          idx_n = bit_idx + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Sampling, shifting, error accumulation and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      bit_idx  <= '0;
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      zero_acc <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      phase   <= phase_n;
      bit_idx <= idx_n;
      valid_q <= 1'b0;
      if (phase == PH_LO)  samp_lo  <= rxs;
      if (phase == PH_MID) samp_mid <= rxs;
      if (start_det) begin
        ferr_acc <= 1'b0;
        zero_acc <= 1'b1;
      end
      if (at_dec) begin
        case (state)
          DATA: begin
            shreg    <= {maj, shreg[DATA_BITS-1:1]};
            zero_acc <= zero_acc & ~maj;
          end
          PARITY: begin
            par_bit  <= maj;
            zero_acc <= zero_acc & ~maj;
          end
          STOP: begin
            ferr_acc <= ferr_acc | ~maj;
            zero_acc <= zero_acc & ~maj;
          end
          default: ;
        endcase
      end
      if (frame_done) begin
        data_q  <= shreg;
        perr_q  <= PEN & ((^shreg) ^ par_bit ^ ODD_BIT);
        ferr_q  <= ferr_acc | ~maj;
        brk_q   <= zero_acc & ~maj;
        valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three configurations (8N1/16x, 8E1/16x, 7O2/8x),
// table vectors, hand-written corner sequences and randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_core;
  logic       clk  = 1'b0;
  logic [2:0] rst  = 3'b111;
  logic [2:0] line = 3'b111;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int dbl    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core_if #(.DATA_BITS(8)) ifa ();
  uart_rx_core_if #(.DATA_BITS(8)) ifb ();
  uart_rx_core_if #(.DATA_BITS(7)) ifc ();
  assign ifa.i_rx_data = line[0];
  assign ifb.i_rx_data = line[1];
  assign ifc.i_rx_data = line[2];

  uart_rx_core #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset(rst[0]), .rx(ifa));
  uart_rx_core #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_b (.clk(clk), .reset(rst[1]), .rx(ifb));
  uart_rx_core #(.OVERSAMPLE(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut_c (.clk(clk), .reset(rst[2]), .rx(ifc));

  typedef struct {
    int         d;
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  typedef struct {
    int         d;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stop;
    logic       gl;
    int         gap;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
    logic       ebr;
  } vec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  logic [2:0] pv = '0;

  // Strobe monitor: records every completed word with its cycle number.
  always @(negedge clk) begin
    if (ifa.o_rx_valid) begin
      got_q.push_back('{0, cyc, {1'b0, ifa.o_rx_data}, ifa.o_parity_err, ifa.o_frame_err, ifa.o_break});
      if (pv[0]) dbl++;
    end
    if (ifb.o_rx_valid) begin
      got_q.push_back('{1, cyc, {1'b0, ifb.o_rx_data}, ifb.o_parity_err, ifb.o_frame_err, ifb.o_break});
      if (pv[1]) dbl++;
    end
    if (ifc.o_rx_valid) begin
      got_q.push_back('{2, cyc, {2'b00, ifc.o_rx_data}, ifc.o_parity_err, ifc.o_frame_err, ifc.o_break});
      if (pv[2]) dbl++;
    end
    pv = {ifc.o_rx_valid, ifb.o_rx_valid, ifa.o_rx_valid};
  end

  function automatic int os_of(int d);  return (d == 2) ? 8 : 16; endfunction
  function automatic int db_of(int d);  return (d == 2) ? 7 : 8;  endfunction
  function automatic int pen_of(int d); return (d == 0) ? 0 : 1;  endfunction
  function automatic int odd_of(int d); return (d == 2) ? 1 : 0;  endfunction
  function automatic int sb_of(int d);  return (d == 2) ? 2 : 1;  endfunction
  function automatic int nbits(int d);  return 1 + db_of(d) + pen_of(d) + sb_of(d); endfunction

  // Cycle (pin-driven-low cycle as reference) on which the strobe must be seen.
  function automatic int exp_cyc(int d, int start);
    return start + 2 + (nbits(d) - 1) * os_of(d) + os_of(d) / 2 + 2;
  endfunction

  function automatic logic [15:0] frame_bits(int d, logic [8:0] data, logic pbit, logic [1:0] stop);
    logic [15:0] b;
    int k;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    for (int i = 0; i < db_of(d); i++) begin b[k] = data[i]; k++; end
    if (pen_of(d) != 0) begin b[k] = pbit; k++; end
    for (int s = 0; s < sb_of(d); s++) begin b[k] = stop[s]; k++; end
    return b;
  endfunction

  // Reference model: what the receiver must report for one frame.
  function automatic rec_t model(int d, logic [8:0] data, logic pbit, logic [1:0] stop, int start);
    rec_t r;
    logic [8:0] m;
    logic odd, allz;
    m     = data & 9'((1 << db_of(d)) - 1);
    odd   = (odd_of(d) != 0);
    r.d   = d;
    r.cyc = exp_cyc(d, start);
    r.data = m;
    r.pe  = (pen_of(d) != 0) && (((^m) ^ pbit) != odd);
    r.fe  = 1'b0;
    allz  = (m == 9'd0) && (pen_of(d) == 0 || pbit == 1'b0);
    for (int s = 0; s < sb_of(d); s++) begin
      if (stop[s] == 1'b0) r.fe = 1'b1;
      else allz = 1'b0;
    end
    r.brk = allz;
    return r;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // gmode 1: invert every data bit at phase MID; gmode 2: invert bit gbit at phase gph.
  task automatic send(int d, logic [8:0] data, logic pbit, logic [1:0] stop, int gmode, int gbit, int gph);
    logic [15:0] b;
    logic v;
    b = frame_bits(d, data, pbit, stop);
    for (int i = 0; i < nbits(d); i++) begin
      for (int p = 0; p < os_of(d); p++) begin
        v = b[i];
        if (gmode == 1 && i >= 1 && i <= db_of(d) && p == os_of(d) / 2) v = ~v;
        if (gmode == 2 && i == gbit && p == gph) v = ~v;
        line[d] = v;
        tick(1);
      end
    end
    line[d] = 1'b1;
  endtask

  task automatic compare_q(string tag);
    rec_t g, e;
    chk($sformatf("%s strobe_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      chk($sformatf("%s[%0d] dut", tag, i), g.d, e.d);
      chk($sformatf("%s[%0d] cycle", tag, i), g.cyc, e.cyc);
      chk($sformatf("%s[%0d] data", tag, i), int'(g.data), int'(e.data));
      chk($sformatf("%s[%0d] parity_err", tag, i), int'(g.pe), int'(e.pe));
      chk($sformatf("%s[%0d] frame_err", tag, i), int'(g.fe), int'(e.fe));
      chk($sformatf("%s[%0d] break", tag, i), int'(g.brk), int'(e.brk));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic busy_of(int d);
    case (d)
      0:       return ifa.o_busy;
      1:       return ifb.o_busy;
      default: return ifc.o_busy;
    endcase
  endfunction

  task automatic check_reset_outs(int d, string tag);
    logic [8:0] data;
    logic v, pe, fe, br, bz;
    case (d)
      0: begin data = {1'b0, ifa.o_rx_data}; v = ifa.o_rx_valid; pe = ifa.o_parity_err;
               fe = ifa.o_frame_err; br = ifa.o_break; bz = ifa.o_busy; end
      1: begin data = {1'b0, ifb.o_rx_data}; v = ifb.o_rx_valid; pe = ifb.o_parity_err;
               fe = ifb.o_frame_err; br = ifb.o_break; bz = ifb.o_busy; end
      default: begin data = {2'b00, ifc.o_rx_data}; v = ifc.o_rx_valid; pe = ifc.o_parity_err;
               fe = ifc.o_frame_err; br = ifc.o_break; bz = ifc.o_busy; end
    endcase
    chk({tag, " data"}, int'(data), 0);
    chk({tag, " valid"}, int'(v), 0);
    chk({tag, " parity_err"}, int'(pe), 0);
    chk({tag, " frame_err"}, int'(fe), 0);
    chk({tag, " break"}, int'(br), 0);
    chk({tag, " busy"}, int'(bz), 0);
  endtask

  localparam int NV = 9;
  vec_t tab [NV];

  initial begin
    int s, d, gap, gmode, gbit, gph, nxt_gap;
    logic prev_err;
    logic [8:0] data;
    logic pbit;
    logic [1:0] stop;
    logic [15:0] b;
    rec_t r;

    //          d  data    pb  stop   gl  gap  exp_data pe fe brk
    tab[0] = '{0, 9'h0A5, 0, 2'b11, 0, 4, 9'h0A5, 0, 0, 0};
    tab[1] = '{0, 9'h0FF, 0, 2'b11, 0, 4, 9'h0FF, 0, 0, 0};
    tab[2] = '{0, 9'h081, 0, 2'b10, 0, 4, 9'h081, 0, 1, 0};
    tab[3] = '{1, 9'h03C, 1, 2'b11, 0, 4, 9'h03C, 1, 0, 0};
    tab[4] = '{1, 9'h03C, 0, 2'b11, 0, 4, 9'h03C, 0, 0, 0};
    tab[5] = '{1, 9'h001, 1, 2'b11, 0, 4, 9'h001, 0, 0, 0};
    tab[6] = '{2, 9'h000, 1, 2'b11, 1, 4, 9'h000, 0, 0, 0};
    tab[7] = '{2, 9'h07F, 0, 2'b11, 1, 0, 9'h07F, 0, 0, 0};
    tab[8] = '{2, 9'h02A, 0, 2'b11, 1, 0, 9'h02A, 0, 0, 0};

    // Reset state.
    tick(3);
    for (int i = 0; i < 3; i++) check_reset_outs(i, $sformatf("reset%0d", i));
    rst = 3'b000;
    tick(4);

    // Table vectors; back-to-back rows are sent without a gap and checked as a group.
    for (int i = 0; i < NV; i++) begin
      d = tab[i].d;
      tick(tab[i].gap);
      exp_q.push_back('{d, exp_cyc(d, cyc), tab[i].ed, tab[i].epe, tab[i].efe, tab[i].ebr});
      send(d, tab[i].data, tab[i].pbit, tab[i].stop, tab[i].gl ? 1 : 0, 0, 0);
      nxt_gap = (i + 1 < NV) ? tab[i + 1].gap : 1;
      if (nxt_gap != 0) begin
        tick(3 * os_of(d));
        compare_q($sformatf("vec%0d", i));
      end
    end
    chk("busy_after_frames", int'(busy_of(0)), 0);

    // False start: 4 low cycles, back to idle by cycle 10, then a good frame.
    s = cyc;
    line[0] = 1'b0;
    tick(4);
    line[0] = 1'b1;
    tick(s + 7 - cyc);
    chk("false_start busy_mid", int'(busy_of(0)), 1);
    tick(s + 12 - cyc);
    chk("false_start busy_idle", int'(busy_of(0)), 0);
    tick(16);
    exp_q.push_back(model(0, 9'h03C, 1'b0, 2'b11, cyc));
    send(0, 9'h03C, 1'b0, 2'b11, 0, 0, 0);
    tick(48);
    compare_q("false_start");

    // Break: line low for three frame times gives a single break word.
    s = cyc;
    exp_q.push_back('{0, exp_cyc(0, s), 9'h000, 1'b0, 1'b1, 1'b1});
    line[0] = 1'b0;
    tick(3 * 10 * 16);
    line[0] = 1'b1;
    tick(16);
    exp_q.push_back(model(0, 9'h055, 1'b0, 2'b11, cyc));
    send(0, 9'h055, 1'b0, 2'b11, 0, 0, 0);
    tick(48);
    compare_q("break");

    // Reset in the middle of data bit 3, then a clean frame.
    b = frame_bits(0, 9'h05A, 1'b0, 2'b11);
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 16; p++) begin line[0] = b[i]; tick(1); end
    for (int p = 0; p < 8; p++) begin line[0] = b[4]; tick(1); end
    rst[0] = 1'b1;
    line[0] = 1'b1;
    tick(1);
    check_reset_outs(0, "midreset");
    rst[0] = 1'b0;
    tick(16);
    exp_q.push_back(model(0, 9'h0C3, 1'b0, 2'b11, cyc));
    send(0, 9'h0C3, 1'b0, 2'b11, 0, 0, 0);
    tick(48);
    compare_q("midreset");

    // Randomized frames with parity/stop errors, short gaps and single-sample glitches.
    for (int dd = 0; dd < 3; dd++) begin
      prev_err = 1'b0;
      for (int k = 0; k < 8; k++) begin
        data = 9'($urandom);
        pbit = 1'($urandom);
        stop = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        gap  = prev_err ? int'($urandom_range(2, os_of(dd))) : int'($urandom_range(0, os_of(dd)));
        tick(gap);
        r = model(dd, data, pbit, stop, cyc);
        gmode = 0; gbit = 0; gph = 0;
        if (!r.fe && $urandom_range(0, 1) == 1) begin
          gmode = 2;
          gbit  = int'($urandom_range(0, nbits(dd) - sb_of(dd) - 1));
          gph   = os_of(dd) / 2 - 1 + int'($urandom_range(0, 2));
        end
        exp_q.push_back(r);
        send(dd, data, pbit, stop, gmode, gbit, gph);
        prev_err = r.fe;
      end
      tick(3 * os_of(dd));
      compare_q($sformatf("rand%0d", dd));
    end

    chk("no_double_strobe", dbl, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive engine for the serial controller: it recovers asynchronous frames from a single serial input line. Data width, parity mode, stop-bit count and oversampling ratio are set by parameters. It adds an input synchroniser, 3-sample majority voting, parity, framing and break detection, and a one-cycle valid strobe. It sits between the pad-side `i_rx_data` line and the receive FIFO or register interface, and it is the successor to the fixed 8N1 receiver.

## Interface
- `OVERSAMPLE`, 16: clock cycles per bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9. Bits arrive LSB first.
- `PARITY_EN`, 0: 1 = a parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  the only clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  1  asynchronous serial line. Idles high.
- `o_rx_data`  out  DATA_BITS  last received word. Held until the next `o_rx_valid`.
- `o_rx_valid`  out  1  one-cycle strobe when a frame completes.
- `o_parity_err`  out  1  parity mismatch for the word in `o_rx_data`. Updated with `o_rx_valid`.
- `o_frame_err`  out  1  at least one stop bit sampled as 0. Updated with `o_rx_valid`.
- `o_break`  out  1  every bit of the frame (start, data, parity, stop) was sampled as 0. Updated with `o_rx_valid`.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Input synchroniser:** two flops in series, both reset to 1. All logic below sees only the synchronised line `rxs`.
- **Timing counters:**
  - Bit-phase counter is `$clog2(OVERSAMPLE)` bits wide. It runs 0..OVERSAMPLE-1 inside each bit and wraps at the bit boundary.
  - Bit index counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- **Majority sampling:** with MID = OVERSAMPLE/2, `rxs` is captured at phases MID-1, MID and MID+1. The bit value is the 2-of-3 majority, decided at phase MID+1.
- **States:**
  - **IDLE:** waits for `rxs` falling from 1 to 0. The previous `rxs` must have been 1, so a line held low never retriggers. On detection, phase = 0 and the state moves to START.
  - **START:** at the majority decision:
    - bit = 1 → false start. Return to IDLE with no outputs changed.
    - bit = 0 → continue. At phase OVERSAMPLE-1, move to DATA.
  - **DATA:** each majority bit is shifted in, LSB first. After bit DATA_BITS-1 completes its phase, go to PARITY if `PARITY_EN`, otherwise STOP.
  - **PARITY:** sample the parity bit. Error when the XOR of data bits and parity bit ≠ `PARITY_ODD`. At phase OVERSAMPLE-1, go to STOP.
  - **STOP:** sample each stop bit; any 0 sets the frame error. At the majority decision of the last stop bit, the frame completes:
    - load `o_rx_data`, `o_parity_err`, `o_frame_err` and `o_break`;
    - pulse `o_rx_valid` in the next cycle;
    - return to IDLE immediately, without waiting for the rest of the stop bit, so back-to-back frames can resynchronise.
  - **Undefined state encodings:** go to IDLE.
- **Error flags:** reported together with the data, never separately. With `PARITY_EN` = 0, `o_parity_err` is always 0.
- **Unused data bits:** for DATA_BITS < width of any downstream bus, the upper bits are the block's concern only. `o_rx_data` is exactly DATA_BITS wide.

## Timing
- **Reset values:** `o_rx_data` = 0, `o_rx_valid` = 0, `o_parity_err` = 0, `o_frame_err` = 0, `o_break` = 0, `o_busy` = 0. The state is IDLE and the synchroniser flops hold 1.
- **Reset mid-frame:** the frame in progress is aborted with no `o_rx_valid`. After reset, a new start is recognised only after `rxs` has been seen high.
- **Latency:**
  - Pin edge to `rxs` takes 2 cycles.
  - Let cycle 0 be the first cycle with `rxs` = 0 in IDLE, and N = 1 + DATA_BITS + PARITY_EN + STOP_BITS.
  - `o_rx_valid` is high in cycle (N-1)·OVERSAMPLE + MID + 2.
  - Example, 8N1 with OVERSAMPLE = 16: cycle 154.
- **Valid strobe:** `o_rx_valid` is exactly one cycle wide. It is never asserted on two consecutive cycles.
- **Start of next frame:** a falling edge arriving at any time after return to IDLE starts a new frame. This includes the cycle immediately after.
- **Glitch rejection:** a single-cycle glitch at any of the three sample points does not change the decided bit value.

## Test plan
- **Nominal 8N1:** OVERSAMPLE = 16, send 0xA5 → `o_rx_data` = 0xA5 and `o_rx_valid` high in cycle 154 only; `o_parity_err` = `o_frame_err` = `o_break` = 0; `o_busy` low afterwards.
- **False start:** line low for 4 cycles then high → no `o_rx_valid`, `o_busy` back to 0 by cycle 10. A following valid frame of 0x3C is received correctly.
- **Parity error:** 8E1, send 0x3C with parity bit 1 → `o_rx_data` = 0x3C, `o_parity_err` = 1, `o_frame_err` = 0. The same frame with parity bit 0 → `o_parity_err` = 0.
- **Frame error and break:**
  - Stop bit driven 0 on frame 0x81 → `o_frame_err` = 1, `o_break` = 0.
  - Line held low for 3 frame times → exactly one `o_rx_valid`, with data 0x00, `o_frame_err` = 1 and `o_break` = 1. No further strobe until the line goes high and a new frame 0x55 arrives, which is received cleanly.
- **Back-to-back with noise:** 7O2 and OVERSAMPLE = 8, send 0x00, 0x7F and 0x2A with zero idle gap and a 1-cycle glitch at phase MID of every data bit → all three words are received in order with no errors.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 3 → all outputs at reset values, no strobe. Then line high for 1 bit time and send 0xC3 → received correctly.
